// File: rtl/uart_rx.sv
// uart_rx: serial-to-parallel UART receiver.
// Frame: start(0), 8 data bits LSB-first, optional even parity, stop(1).
// Samples at mid-bit, rejects short start glitches, and reports framing and
// parity errors as one-cycle pulses.
module uart_rx #(
   parameter int CLKS_PER_BIT = 10,
   parameter int PARITY_EN    = 0
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Active,
   output logic       o_Rx_Frame_Err,
   output logic       o_Rx_Parity_Err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      idx;
   logic [7:0]      shift;
   logic            par_err;
   logic            rx_meta;
   logic            rx_s;

   // Two-flop synchroniser; resets to idle-high so no false start after reset.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_Rx_Serial;
         rx_s    <= rx_meta;
      end
   end

   // Receive FSM with registered outputs; pulses default low every cycle.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state           <= S_IDLE;
         cnt             <= '0;
         idx             <= '0;
         shift           <= '0;
         par_err         <= 1'b0;
         o_Rx_DV         <= 1'b0;
         o_Rx_Byte       <= '0;
         o_Rx_Active     <= 1'b0;
         o_Rx_Frame_Err  <= 1'b0;
         o_Rx_Parity_Err <= 1'b0;
      end else begin
         o_Rx_DV         <= 1'b0;
         o_Rx_Frame_Err  <= 1'b0;
         o_Rx_Parity_Err <= 1'b0;
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (!rx_s) begin
                  state       <= S_START;
                  o_Rx_Active <= 1'b1;
                  par_err     <= 1'b0;
               end
            end
            S_START: begin
               if (cnt == CNT_HALF) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state <= S_DATA;
                     idx   <= '0;
                  end else begin
                     state       <= S_IDLE;
                     o_Rx_Active <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt        <= '0;
                  shift[idx] <= rx_s;
                  if (idx == 3'd7) begin
                     state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (cnt == CNT_LAST) begin
                  cnt     <= '0;
                  par_err <= ^{shift, rx_s};
                  state   <= S_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     // Leave at mid-stop so a back-to-back start edge is not missed.
                     state       <= S_IDLE;
                     o_Rx_Active <= 1'b0;
                     if (par_err) begin
                        o_Rx_Parity_Err <= 1'b1;
                     end else begin
                        o_Rx_DV   <= 1'b1;
                        o_Rx_Byte <= shift;
                     end
                  end else begin
                     state          <= S_BREAK;
                     o_Rx_Frame_Err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_BREAK: begin
               cnt <= '0;
               if (rx_s) begin
                  state       <= S_IDLE;
                  o_Rx_Active <= 1'b0;
               end
            end
            default: begin
               state       <= S_IDLE;
               o_Rx_Active <= 1'b0;
            end
         endcase
      end
   end

endmodule
